// File: rtl/multiword_add_sub_sequencer.sv
// ============================================================================
// multiword_add_sub_sequencer: runs NUM_WORDS-word add/sub on one external
// DATA_WIDTH-bit adder, LSW first, chaining carry between words.
// Rev 1.0
// ============================================================================
`default_nettype none

module multiword_add_sub_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 2
) (
  input  logic                            CLK,
  input  logic                            RST_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] A_in,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] B_in,
  input  logic                            SUB,
  output logic [DATA_WIDTH-1:0]           ADD_A,
  output logic [DATA_WIDTH-1:0]           ADD_B,
  output logic                            ADD_Cin,
  input  logic [DATA_WIDTH-1:0]           ADD_S,
  input  logic                            ADD_CF,
  input  logic                            ADD_OF,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] S_out,
  output logic                            CF_out,
  output logic                            OF_out,
  output logic                            Z_out
);

  localparam int W  = DATA_WIDTH * NUM_WORDS;
  localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [KW-1:0]         k;
  logic [W-1:0]          a_reg;
  logic [W-1:0]          b_reg;
  logic [W-1:0]          s_reg;
  logic [W-1:0]          s_next;
  logic                  sub_reg;
  logic                  carry_reg;
  logic                  of_reg;
  logic                  z_reg;
  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] b_word;
  logic                  run;

  // Word mux and result merge; s_next is only consumed while in RUN.
  always_comb begin
    a_word = '0;
    b_word = '0;
    s_next = s_reg;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (k == KW'(i)) begin
        a_word = a_reg[i*DATA_WIDTH +: DATA_WIDTH];
        b_word = b_reg[i*DATA_WIDTH +: DATA_WIDTH];
        s_next[i*DATA_WIDTH +: DATA_WIDTH] = ADD_S;
      end
    end
  end

  assign run     = (state == RUN);
  assign ADD_A   = run ? a_word : '0;
  assign ADD_B   = run ? (sub_reg ? ~b_word : b_word) : '0;
  assign ADD_Cin = run & carry_reg;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      k         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      of_reg    <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A_in;
            b_reg     <= B_in;
            sub_reg   <= SUB;
            carry_reg <= SUB;
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          s_reg     <= s_next;
          carry_reg <= ADD_CF;
          of_reg    <= ADD_OF;
          if (k == K_LAST) begin
            z_reg <= (s_next == '0);
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Subtraction carry is an inverted borrow, so flip it back for CF_out.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign S_out     = s_reg;
  assign CF_out    = carry_reg ^ sub_reg;
  assign OF_out    = of_reg;
  assign Z_out     = z_reg;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sub_sequencer.sv
// ============================================================================
// tb_multiword_add_sub_sequencer: self-checking bench with a behavioural
// adder stand-in and a full-width arithmetic reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multiword_add_sub_sequencer;

  localparam int DW = 16;
  localparam int NW = 2;
  localparam int W  = DW * NW;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A_in = '0;
  logic [W-1:0]  B_in = '0;
  logic          SUB = 1'b0;
  logic [DW-1:0] ADD_A;
  logic [DW-1:0] ADD_B;
  logic          ADD_Cin;
  logic [DW-1:0] ADD_S;
  logic          ADD_CF;
  logic          ADD_OF;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  S_out;
  logic          CF_out;
  logic          OF_out;
  logic          Z_out;

  int errors = 0;
  int checks = 0;

  multiword_add_sub_sequencer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .SUB(SUB),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_Cin(ADD_Cin),
    .ADD_S(ADD_S), .ADD_CF(ADD_CF), .ADD_OF(ADD_OF),
    .out_valid(out_valid), .out_ready(out_ready),
    .S_out(S_out), .CF_out(CF_out), .OF_out(OF_out), .Z_out(Z_out)
  );

  // Combinational adder stand-in.
  assign {ADD_CF, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{DW{1'b0}}, ADD_Cin};
  assign ADD_OF = (ADD_A[DW-1] == ADD_B[DW-1]) && (ADD_S[DW-1] != ADD_A[DW-1]);

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic cf, output logic of,
                                output logic z);
    logic [W:0] u;
    logic [W:0] sg;
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b};
      cf = (a < b);
      sg = {a[W-1], a} - {b[W-1], b};
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      cf = u[W];
      sg = {a[W-1], a} + {b[W-1], b};
    end
    s  = u[W-1:0];
    of = sg[W] ^ sg[W-1];
    z  = (s == '0);
  endfunction

  // Presents one request, scrambles the inputs after acceptance and waits
  // for out_valid. lat counts edges after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic cf, output logic of,
                        output logic z, output int lat, output bit timed_out);
    @(negedge CLK);
    A_in = a; B_in = b; SUB = sub; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; A_in = $urandom; B_in = $urandom; SUB = ~sub;
    lat = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      lat++;
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    s = S_out; cf = CF_out; of = OF_out; z = Z_out;
  endtask

  task automatic release_result();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: in_ready/out_valid=%b%b expected 10", in_ready, out_valid);
    end
    checks++;
    if ({S_out, CF_out, OF_out, Z_out, ADD_A, ADD_B, ADD_Cin} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: S=%h CF=%b OF=%b Z=%b A=%h B=%h Cin=%b expected all 0",
               S_out, CF_out, OF_out, Z_out, ADD_A, ADD_B, ADD_Cin);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_idle: in_ready/out_valid=%b%b expected 10", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{32'h0000F077, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00050000};
    logic [W-1:0] tb [5] = '{32'h00007777, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00010000};
    logic         tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ts [5] = '{32'h000167EE, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h00040000};
    logic [2:0]   tf [5] = '{3'b000, 3'b101, 3'b010, 3'b100, 3'b000};  // {CF,OF,Z}
    logic [W-1:0] s;
    logic cf, of, z;
    int lat;
    bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tsub[i], s, cf, of, z, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: out_valid never rose, expected after %0d edges", i, NW);
      end
      checks++;
      // Including the accept edge this is NUM_WORDS+1 edges.
      if (lat != NW) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges expected %0d", i, lat, NW);
      end
      checks++;
      if ({s, cf, of, z} !== {ts[i], tf[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: S=%h CF=%b OF=%b Z=%b expected S=%h CF/OF/Z=%b",
                 i, s, cf, of, z, ts[i], tf[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es;
    logic sub, cf, of, z, ecf, eof, ez;
    int lat;
    bit to;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        1: b = a;
        2: a[DW-1:0] = '1;
        3: b[W-1] = ~a[W-1];
        default: ;
      endcase
      model(a, b, sub, es, ecf, eof, ez);
      run_op(a, b, sub, s, cf, of, z, lat, to);
      checks++;
      if (to || {s, cf, of, z} !== {es, ecf, eof, ez}) begin
        errors++;
        $display("FAIL random_result[%0d]: A=%h B=%h SUB=%b got S=%h CF=%b OF=%b Z=%b to=%b expected S=%h CF=%b OF=%b Z=%b",
                 i, a, b, sub, s, cf, of, z, to, es, ecf, eof, ez);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, s, es;
    logic cf, of, z, ecf, eof, ez;
    int lat;
    bit to;
    a = 32'h1234FFFF; b = 32'h00000001;
    model(a, b, 1'b0, es, ecf, eof, ez);
    run_op(a, b, 1'b0, s, cf, of, z, lat, to);
    checks++;
    if (to || {s, cf, of, z} !== {es, ecf, eof, ez}) begin
      errors++;
      $display("FAIL bp_result: S=%h CF=%b OF=%b Z=%b expected S=%h CF=%b OF=%b Z=%b",
               s, cf, of, z, es, ecf, eof, ez);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      A_in = $urandom;
      checks++;
      if ({out_valid, in_ready, S_out, CF_out, OF_out, Z_out} !== {2'b10, es, ecf, eof, ez} ||
          {ADD_A, ADD_B, ADD_Cin} !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b S=%h CF=%b OF=%b Z=%b adder=%h/%h/%b expected valid=1 ready=0 S=%h adder=0",
                 c, out_valid, in_ready, S_out, CF_out, OF_out, Z_out, ADD_A, ADD_B, ADD_Cin, es);
      end
    end
    release_result();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: in_ready/out_valid=%b%b expected 10", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] expq [$];
    int accepts [$];
    logic [W-1:0] es, na, nb;
    logic ecf, eof, ez;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result S=%h expected none", S_out);
        end else begin
          es = expq.pop_front();
          if (S_out !== es) begin
            errors++;
            $display("FAIL b2b_result: S=%h expected %h", S_out, es);
          end
        end
      end
      in_valid = 1'b0;
      if (c < 18 && in_ready) begin
        na = $urandom; nb = $urandom;
        model(na, nb, 1'b0, es, ecf, eof, ez);
        expq.push_back(es);
        accepts.push_back(c);
        A_in = na; B_in = nb; SUB = 1'b0; in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (expq.size() != 0 || accepts.size() < 4) begin
      errors++;
      $display("FAIL b2b_count: pending=%0d accepts=%0d expected pending=0 accepts>=4",
               expq.size(), accepts.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++;
      if (accepts[i] - accepts[i-1] != NW + 2) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: gap=%0d cycles expected %0d", i, accepts[i] - accepts[i-1], NW + 2);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] s, es;
    logic cf, of, z, ecf, eof, ez;
    int lat;
    bit to;
    @(negedge CLK);
    A_in = 32'hDEADBEEF; B_in = 32'h12345678; SUB = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 ||
        {S_out, CF_out, OF_out, Z_out, ADD_A, ADD_B, ADD_Cin} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b ready=%b S=%h CF=%b OF=%b Z=%b adder=%h/%h/%b expected ready=1 rest 0",
               out_valid, in_ready, S_out, CF_out, OF_out, Z_out, ADD_A, ADD_B, ADD_Cin);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL midreset_idle[%0d]: valid=%b ready=%b expected 0/1", c, out_valid, in_ready);
      end
    end
    model(32'h89ABCDEF, 32'h76543211, 1'b1, es, ecf, eof, ez);
    run_op(32'h89ABCDEF, 32'h76543211, 1'b1, s, cf, of, z, lat, to);
    checks++;
    if (to || lat != NW || {s, cf, of, z} !== {es, ecf, eof, ez}) begin
      errors++;
      $display("FAIL midreset_fresh: S=%h CF=%b OF=%b Z=%b lat=%0d expected S=%h CF=%b OF=%b Z=%b lat=%0d",
               s, cf, of, z, lat, es, ecf, eof, ez, NW);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiword_add_sub_sequencer.md
# multiword_add_sub_sequencer

Sequential controller that sits directly upstream of the combinational `carry_lookahead_adder`. It performs NUM_WORDS×DATA_WIDTH-bit additions and subtractions on a single DATA_WIDTH-bit adder instance, least-significant word first, chaining the adder's carry between words. It drives the adder's A/B/Cin and consumes its S/CF/OF. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- DATA_WIDTH, 16: width of the attached adder (its DATA_WIDTH).
- NUM_WORDS, 2: words per operand. Must be ≥1. Full operand width W = DATA_WIDTH*NUM_WORDS.

Ports:
- CLK  in  1  the block's only clock; all state changes on its rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- A_in  in  W  operand A, unsigned or two's complement.
- B_in  in  W  operand B.
- SUB  in  1  0 computes A+B; 1 computes A−B.
- ADD_A  out  DATA_WIDTH  to adder A.
- ADD_B  out  DATA_WIDTH  to adder B.
- ADD_Cin  out  1  to adder Cin.
- ADD_S  in  DATA_WIDTH  from adder S.
- ADD_CF  in  1  from adder CF (carry out).
- ADD_OF  in  1  from adder OF.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- S_out  out  W  result.
- CF_out  out  1  add: carry out of the MSB; sub: borrow (1 when A<B unsigned).
- OF_out  out  1  signed overflow of the full-width operation.
- Z_out  out  1  1 when S_out is all zero.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is 1, register A_in, B_in and SUB, clear the word counter k, load carry_reg with SUB, and go to RUN.
- RUN, cycle k (0..NUM_WORDS−1):
  - ADD_A = A_reg word k.
  - ADD_B = B_reg word k, or its bitwise inverse when SUB=1.
  - ADD_Cin = carry_reg.
  - At the clock edge: S_reg word k ← ADD_S, carry_reg ← ADD_CF, of_reg ← ADD_OF.
  - When k=NUM_WORDS−1, go to DONE. Otherwise k ← k+1.
- Adder drive outside RUN: ADD_A, ADD_B and ADD_Cin are held at 0.
- DONE:
  - out_valid=1.
  - S_out=S_reg.
  - CF_out = carry_reg XOR SUB_reg.
  - OF_out = of_reg, which is the OF of the last word.
  - Z_out = (S_reg==0).
  - When out_ready is 1, go to IDLE.
- Output stability: S_out, CF_out, OF_out and Z_out are registered. They hold their value from the end of RUN until the next accept. Their value is only meaningful while out_valid=1.
- Operand capture: changes on A_in, B_in or SUB after acceptance have no effect on the operation in flight.
- in_ready is 0 in RUN and DONE. The block never accepts a new request in the same cycle a result is consumed.
- Word counter width: max(1, $clog2(NUM_WORDS)).
- NUM_WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset (RST_n=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - S_out=0, CF_out=0, OF_out=0, Z_out=0 (the Z register resets to 0).
  - ADD_A, ADD_B and ADD_Cin are 0.
  - carry_reg, of_reg and k are 0.
- Reset mid-RUN or mid-DONE: the operation is discarded and no result is produced. After deassertion the block is in IDLE with in_ready=1.
- Accept at rising edge t (in_valid & in_ready): RUN is active during cycles t..t+NUM_WORDS−1 after that edge.
- Result: out_valid rises after edge t+NUM_WORDS. Latency from accept to valid is NUM_WORDS+1 edges.
- Release: out_valid & out_ready at edge u gives out_valid=0 and in_ready=1 after u. The next accept is possible at edge u+1.
- Throughput: with out_ready held at 1, at most one operation per NUM_WORDS+2 cycles.
- Back-pressure: while out_ready=0 in DONE, all outputs are held stable indefinitely.
- Adder path: the attached adder is purely combinational. The ADD_A → ADD_S path must close within one CLK period.

## Test plan
All scenarios use DATA_WIDTH=16, NUM_WORDS=2, with the real `carry_lookahead_adder` attached.
- Carry chaining: A=0x0000F077, B=0x00007777, SUB=0 → S_out=0x000167EE, CF=0, OF=0, Z=0. out_valid rises 3 edges after accept.
- Wrap to zero: A=0xFFFFFFFF, B=0x00000001, SUB=0 → S_out=0x00000000, CF=1, OF=0, Z=1.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, SUB=0 → S_out=0x80000000, CF=0, OF=1, Z=0.
- Borrow: A=0x00000000, B=0x00000001, SUB=1 → S_out=0xFFFFFFFF, CF=1, OF=0. Also A=0x00050000, B=0x00010000, SUB=1 → S_out=0x00040000, CF=0.
- Back-pressure and capture:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout.
  - Toggle A_in after accept → result unaffected.
  - Raise out_ready → in_ready=1 on the next cycle.
  - Check that back-to-back operations complete every 4 cycles.
- Reset mid-operation: assert RST_n=0 during RUN cycle 1 → out_valid=0, in_ready=1 and all outputs 0 immediately. A fresh request afterwards completes correctly.
